serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Serial frame transmitter for the sequence-detector family. Accepts a
//  parallel payload word over a valid/ready handshake and shifts out one bit
//  per clock, MSB-first: first a fixed sync header (default 11011), then the
//  payload, then a guard gap of zeros.
//  Drives the single-bit "in" of a sequence detector such as the 11011 Mealy
//  detector, as a stimulus/link source.
// PARAMETERS
//  DATA_W      8         payload width in bits, >=1
//  SYNC_W      5         sync header width in bits, 1..16
//  SYNC_PAT    5'b11011  sync header value, sent MSB-first
//  GAP_CYCLES  2         guard zero-bit cycles after the payload, 0..15
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous reset, active-low (0 = in reset)
//  load_valid   in   1       payload offered
//  load_ready   out  1       transmitter can accept (high only in IDLE)
//  load_data    in   DATA_W  payload, captured on handshake
//  out          out  1       serial bit, registered
//  out_valid    out  1       high while sync or payload bits are on out
//  sync_active  out  1       high while sync header bits are on out
//  busy         out  1       high in SYNC, DATA and GAP
//  done         out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; out, out_valid, sync_active, busy and
//    done are 0; shift register and counters are cleared; load_ready=0 while
//    rst=0.
//  - load_ready = (state==IDLE) && rst. A handshake occurs when load_valid and
//    load_ready are both high at a rising edge. load_data is captured at that
//    edge. load_valid outside IDLE is ignored and nothing is queued.
//  - FSM IDLE -> SYNC -> DATA -> GAP -> IDLE. GAP is skipped when
//    GAP_CYCLES=0 (DATA -> IDLE).
//  - Latency: for a handshake at edge k, the first sync bit is on out during
//    cycle k+1. All outputs are register outputs.
//  - SYNC: SYNC_W cycles, out = SYNC_PAT[SYNC_W-1-i],
//    out_valid=1, sync_active=1.
//  - DATA: DATA_W cycles, out = payload bit MSB..LSB, out_valid=1,
//    sync_active=0.
//  - GAP: GAP_CYCLES cycles, out=0, out_valid=0.
//  - done=1 for exactly the first IDLE cycle after the frame. load_ready=1 in
//    that same cycle, so a new handshake at its end gives back-to-back frames.
//  - Minimum frame period = 1+SYNC_W+DATA_W+GAP_CYCLES cycles
//    (16 with defaults).
//  - In IDLE and GAP: out=0, out_valid=0, sync_active=0. busy=0 only in IDLE.
//  - Bit counter width = clog2(max(SYNC_W,DATA_W,GAP_CYCLES)+1). The counter
//    reloads on every state change and never wraps inside a state.
//  - Reset mid-frame aborts immediately. No done pulse. The partial frame is
//    discarded, and after rst rises the block waits in IDLE for a new
//    handshake.
//  - Out-of-range parameters must be rejected at elaboration ($error in an
//    initial/generate check).
// TESTING
//  1. Reset: rst=0 for 10 ns with load_valid=1 -> all outputs 0 and no
//     capture. After release -> load_ready=1, out=0.
//  2. load_data=8'hA5, single handshake -> out = 1101110100101 over 13
//     cycles, then 2 cycles of 0, done pulse in cycle 16 after the handshake.
//     A detector on out pulses exactly once, on the 5th bit.
//  3. load_data=8'hDB -> out stream 1101111011011. The overlapping 11011
//     detector pulses 3 times, on the 5th, 10th and 13th bits.
//  4. load_valid held high with two payloads queued by the bench -> second
//     frame's first sync bit appears the cycle after done. Period is exactly
//     16 cycles.
//  5. Handshake, then load_valid pulsed during DATA with new data -> ignored.
//     The frame is unchanged and load_ready=0 until done.
//  6. rst=0 during the 3rd payload bit -> outputs 0 asynchronously and no
//     done pulse. The next handshake sends a clean full frame.
//     GAP_CYCLES=0 rerun -> done follows the last payload bit directly.

Source files
------------

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: sync header, MSB-first payload, zero guard gap
//
// Purpose:
//   Accepts a parallel payload word over a valid/ready handshake and shifts
//   it out one bit per clock. Each frame is a fixed sync header, then the
//   payload MSB-first, then GAP_CYCLES guard bits of zero. Typical use is
//   driving the serial input of a sequence detector (e.g. an 11011 detector).
//
// Parameters:
//   DATA_W      payload width, >= 1
//   SYNC_W      sync header width, 1..16
//   SYNC_PAT    sync header value, sent MSB-first
//   GAP_CYCLES  zero guard cycles after the payload, 0..15 (0 skips GAP)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   load_valid   payload offered
//   load_ready   transmitter can accept (IDLE and out of reset)
//   load_data    payload, captured on the handshake edge
//   out          serial bit (registered)
//   out_valid    high while sync or payload bits are on out
//   sync_active  high while sync header bits are on out
//   busy         high in SYNC, DATA and GAP
//   done         one-cycle pulse in the first IDLE cycle after a frame

module serial_frame_tx #(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = 5,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = 5'b11011,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              out,
  output logic              out_valid,
  output logic              sync_active,
  output logic              busy,
  output logic              done
);

  // Elaboration-time parameter range checks.
  generate
    if (DATA_W < 1) begin : g_chk_data_w
      $error("serial_frame_tx: DATA_W must be >= 1");
    end
    if ((SYNC_W < 1) || (SYNC_W > 16)) begin : g_chk_sync_w
      $error("serial_frame_tx: SYNC_W must be in 1..16");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_chk_gap
      $error("serial_frame_tx: GAP_CYCLES must be in 0..15");
    end
  endgenerate

  // The counter holds "cycles remaining in this state after the current
  // one", so it only ever needs to reach max(SYNC_W, DATA_W, GAP_CYCLES)-1.
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_LEN = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic [SYNC_W-1:0]   sync_sh_q, sync_sh_d;
  logic                out_d, out_valid_d, sync_active_d, busy_d, done_d;
  logic                handshake;

  assign load_ready = (state_q == S_IDLE) && rst;
  assign handshake  = load_valid && load_ready;

  // State and registered outputs. Outputs are computed one cycle ahead so
  // the bit on 'out' always lines up with the state that produced it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_sh_q   <= '0;
      sync_sh_q   <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      sync_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_sh_q   <= data_sh_d;
      sync_sh_q   <= sync_sh_d;
      out         <= out_d;
      out_valid   <= out_valid_d;
      sync_active <= sync_active_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_sh_d     = data_sh_q;
    sync_sh_d     = sync_sh_q;
    out_d         = 1'b0;
    out_valid_d   = 1'b0;
    sync_active_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          // First sync bit goes out straight from the parameter; the shift
          // register holds the remaining header bits.
          state_d       = S_SYNC;
          cnt_d         = SYNC_LAST;
          sync_sh_d     = SYNC_PAT << 1;
          data_sh_d     = load_data;
          out_d         = SYNC_PAT[SYNC_W-1];
          out_valid_d   = 1'b1;
          sync_active_d = 1'b1;
          busy_d        = 1'b1;
        end
      end

      S_SYNC: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d   = S_DATA;
          cnt_d     = DATA_LAST;
          out_d     = data_sh_q[DATA_W-1];
          data_sh_d = data_sh_q << 1;
        end else begin
          cnt_d         = cnt_q - 1'b1;
          out_d         = sync_sh_q[SYNC_W-1];
          sync_sh_d     = sync_sh_q << 1;
          sync_active_d = 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LAST;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d       = cnt_q - 1'b1;
          out_d       = data_sh_q[DATA_W-1];
          data_sh_d   = data_sh_q << 1;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed self-checking bench for serial_frame_tx
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, out, out_valid, sync_active, busy, done;

  logic       g0_load_valid = 1'b0;
  logic [7:0] g0_load_data = 8'h00;
  logic       g0_load_ready, g0_out, g0_out_valid, g0_sync_active, g0_busy, g0_done;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b11011), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .out(out), .out_valid(out_valid),
    .sync_active(sync_active), .busy(busy), .done(done)
  );

  serial_frame_tx #(
    .DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b11011), .GAP_CYCLES(0)
  ) dut_g0 (
    .clk(clk), .rst(rst), .load_valid(g0_load_valid), .load_ready(g0_load_ready),
    .load_data(g0_load_data), .out(g0_out), .out_valid(g0_out_valid),
    .sync_active(g0_sync_active), .busy(g0_busy), .done(g0_done)
  );

  // Runs n cycles starting with the edge that sees the caller's load_valid.
  // Cycle c is sampled at the negedge following posedge c. Samples are shifted
  // in so the first cycle ends up in bit n-1.
  task automatic run_cycles(input int n, input int valid_off_at,
                            input int chg_at, input logic [7:0] new_data,
                            input int pulse_at,
                            output logic [47:0] o, output logic [47:0] ov,
                            output logic [47:0] sa, output logic [47:0] bz,
                            output logic [47:0] dn, output logic [47:0] rd);
    o = '0; ov = '0; sa = '0; bz = '0; dn = '0; rd = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (c == valid_off_at) load_valid = 1'b0;
      if (c == chg_at) load_data = new_data;
      if (c == pulse_at) load_valid = 1'b1;
      if (c == pulse_at + 1) load_valid = 1'b0;
      @(negedge clk);
      o  = {o[46:0], out};
      ov = {ov[46:0], out_valid};
      sa = {sa[46:0], sync_active};
      bz = {bz[46:0], busy};
      dn = {dn[46:0], done};
      rd = {rd[46:0], load_ready};
    end
  endtask

  // Overlapping 11011 detector over a 13-bit stream (MSB = first bit);
  // result bit set where a match completes.
  function automatic logic [12:0] detect(input logic [12:0] bits);
    logic [4:0]  win;
    logic [12:0] hits;
    win = '0;
    hits = '0;
    for (int i = 12; i >= 0; i--) begin
      win = {win[3:0], bits[i]};
      hits[i] = (win == 5'b11011);
    end
    return hits;
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b0;
    load_valid = 1'b1;
    load_data = 8'hFF;
    #10;
    obs = {load_ready, out, out_valid, sync_active, busy, done};
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0);
    end
    tests++;
    if (g0_load_ready !== 1'b0 || g0_busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_gap0: got ready=%b busy=%b expected 0 0", g0_load_ready, g0_busy);
    end
    #2;
    load_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {load_ready, out, out_valid, sync_active, busy, done};
    tests++;
    if (obs !== 6'b100000) begin
      failed++;
      $display("FAIL reset_release: got %b expected %b", obs, 6'b100000);
    end
  endtask

  task automatic test_frame_a5();
    logic [47:0] o, ov, sa, bz, dn, rd;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hA5;
    run_cycles(18, 1, -5, 8'h00, -5, o, ov, sa, bz, dn, rd);
    tests++;
    if (o[17:0] !== 18'b1101110100101_000_00) begin
      failed++;
      $display("FAIL a5_out: got %b expected %b", o[17:0], 18'b110111010010100000);
    end
    tests++;
    if (ov[17:0] !== 18'b1111111111111_000_00) begin
      failed++;
      $display("FAIL a5_out_valid: got %b expected %b", ov[17:0], 18'b111111111111100000);
    end
    tests++;
    if (sa[17:0] !== 18'b11111_00000000_000_00) begin
      failed++;
      $display("FAIL a5_sync_active: got %b expected %b", sa[17:0], 18'b111110000000000000);
    end
    tests++;
    if (bz[17:0] !== 18'b1111111111111_110_00) begin
      failed++;
      $display("FAIL a5_busy: got %b expected %b", bz[17:0], 18'b111111111111111000);
    end
    tests++;
    if (dn[17:0] !== 18'b0000000000000_001_00) begin
      failed++;
      $display("FAIL a5_done: got %b expected %b", dn[17:0], 18'b000000000000000100);
    end
    tests++;
    if (rd[17:0] !== 18'b0000000000000_001_11) begin
      failed++;
      $display("FAIL a5_load_ready: got %b expected %b", rd[17:0], 18'b000000000000000111);
    end
    tests++;
    if (detect(o[17:5]) !== 13'b0000100000000) begin
      failed++;
      $display("FAIL a5_detector: got %b expected %b", detect(o[17:5]), 13'b0000100000000);
    end
  endtask

  task automatic test_frame_db();
    logic [47:0] o, ov, sa, bz, dn, rd;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hDB;
    run_cycles(16, 1, -5, 8'h00, -5, o, ov, sa, bz, dn, rd);
    tests++;
    if (o[15:0] !== 16'b1101111011011_000) begin
      failed++;
      $display("FAIL db_out: got %b expected %b", o[15:0], 16'b1101111011011000);
    end
    tests++;
    if (detect(o[15:3]) !== 13'b0000100001001) begin
      failed++;
      $display("FAIL db_detector: got %b expected %b", detect(o[15:3]), 13'b0000100001001);
    end
    tests++;
    if (dn[15:0] !== 16'h0001) begin
      failed++;
      $display("FAIL db_done: got %h expected %h", dn[15:0], 16'h0001);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] o, ov, sa, bz, dn, rd;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hA5;
    // Data switches to DB after the first handshake; valid stays high until
    // the second handshake at the end of the first done cycle.
    run_cycles(34, 17, 2, 8'hDB, -5, o, ov, sa, bz, dn, rd);
    tests++;
    if (o[33:0] !== {16'b1101110100101000, 16'b1101111011011000, 2'b00}) begin
      failed++;
      $display("FAIL b2b_out: got %b expected %b", o[33:0],
               {16'b1101110100101000, 16'b1101111011011000, 2'b00});
    end
    tests++;
    if (dn[33:0] !== {16'h0001, 16'h0001, 2'b00}) begin
      failed++;
      $display("FAIL b2b_done: got %b expected %b", dn[33:0], {16'h0001, 16'h0001, 2'b00});
    end
    tests++;
    if (bz[33:0] !== {16'hFFFE, 16'hFFFE, 2'b00}) begin
      failed++;
      $display("FAIL b2b_busy: got %b expected %b", bz[33:0], {16'hFFFE, 16'hFFFE, 2'b00});
    end
    tests++;
    if (sa[33:0] !== {16'hF800, 16'hF800, 2'b00}) begin
      failed++;
      $display("FAIL b2b_sync_active: got %b expected %b", sa[33:0], {16'hF800, 16'hF800, 2'b00});
    end
  endtask

  task automatic test_ignore_valid();
    logic [47:0] o, ov, sa, bz, dn, rd;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hA5;
    // New data and a valid pulse land in cycle 8 (payload bit 3).
    run_cycles(18, 1, 8, 8'h00, 8, o, ov, sa, bz, dn, rd);
    tests++;
    if (o[17:0] !== 18'b1101110100101_000_00) begin
      failed++;
      $display("FAIL ignore_out: got %b expected %b", o[17:0], 18'b110111010010100000);
    end
    tests++;
    if (rd[17:0] !== 18'b0000000000000_001_11) begin
      failed++;
      $display("FAIL ignore_load_ready: got %b expected %b", rd[17:0], 18'b000000000000000111);
    end
    tests++;
    if (bz[17:0] !== 18'b1111111111111_110_00) begin
      failed++;
      $display("FAIL ignore_busy: got %b expected %b", bz[17:0], 18'b111111111111111000);
    end
  endtask

  task automatic test_reset_midframe();
    logic [47:0] o, ov, sa, bz, dn, rd;
    logic [5:0]  obs;
    logic        any_done, any_busy;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hA5;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    // Cycle 8: third payload bit of A5 is 1.
    tests++;
    if ({out, out_valid} !== 2'b11) begin
      failed++;
      $display("FAIL midframe_pre: got %b expected %b", {out, out_valid}, 2'b11);
    end
    rst = 1'b0;
    #1;
    obs = {load_ready, out, out_valid, sync_active, busy, done};
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL midframe_async: got %b expected %b", obs, 6'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    any_done = 1'b0;
    any_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      any_done = any_done | done;
      any_busy = any_busy | busy;
    end
    tests++;
    if ({any_done, any_busy} !== 2'b00) begin
      failed++;
      $display("FAIL midframe_after: got done/busy %b expected %b", {any_done, any_busy}, 2'b00);
    end
    load_valid = 1'b1;
    load_data = 8'h3C;
    run_cycles(16, 1, -5, 8'h00, -5, o, ov, sa, bz, dn, rd);
    tests++;
    if (o[15:0] !== 16'b1101100111100000) begin
      failed++;
      $display("FAIL midframe_next_out: got %b expected %b", o[15:0], 16'b1101100111100000);
    end
    tests++;
    if (dn[15:0] !== 16'h0001) begin
      failed++;
      $display("FAIL midframe_next_done: got %h expected %h", dn[15:0], 16'h0001);
    end
  endtask

  task automatic test_gap0();
    logic [14:0] o, dn, bz, ov;
    o = '0; dn = '0; bz = '0; ov = '0;
    @(negedge clk);
    g0_load_valid = 1'b1;
    g0_load_data = 8'hA5;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) g0_load_valid = 1'b0;
      @(negedge clk);
      o  = {o[13:0], g0_out};
      dn = {dn[13:0], g0_done};
      bz = {bz[13:0], g0_busy};
      ov = {ov[13:0], g0_out_valid};
    end
    tests++;
    if (o !== 15'b1101110100101_00) begin
      failed++;
      $display("FAIL gap0_out: got %b expected %b", o, 15'b110111010010100);
    end
    tests++;
    if (dn !== 15'b0000000000000_10) begin
      failed++;
      $display("FAIL gap0_done: got %b expected %b", dn, 15'b000000000000010);
    end
    tests++;
    if (bz !== 15'b1111111111111_00) begin
      failed++;
      $display("FAIL gap0_busy: got %b expected %b", bz, 15'b111111111111100);
    end
    tests++;
    if (ov !== 15'b1111111111111_00) begin
      failed++;
      $display("FAIL gap0_out_valid: got %b expected %b", ov, 15'b111111111111100);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_frame_db();
    test_back_to_back();
    test_ignore_valid();
    test_reset_midframe();
    test_gap0();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
